// File: rtl/vigna_bus_arbiter_if.sv
// Generic vigna valid/ready memory bus: a requester drives the master side, a responder the slave side.
interface vigna_bus_arbiter_if #(
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 32
);
    logic            valid;
    logic            ready;
    logic [AW-1:0]   addr;
    logic [DW-1:0]   wdata;
    logic [DW/8-1:0] wstrb;
    logic [DW-1:0]   rdata;

    modport master (output valid, addr, wdata, wstrb, input ready, rdata);
    modport slave  (input valid, addr, wdata, wstrb, output ready, rdata);
endinterface

// File: rtl/vigna_bus_arbiter.sv
// Merges the vigna instruction and data buses onto one shared memory port, one transaction at a time.
// Define ARB_ROUND_ROBIN_EN to alternate grants on simultaneous requests instead of data priority.
module vigna_bus_arbiter #(
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 32
) (
    input  logic                 clk,
    input  logic                 resetn,
    vigna_bus_arbiter_if.slave   ibus,
    vigna_bus_arbiter_if.slave   dbus,
    vigna_bus_arbiter_if.master  mbus,
    output logic                 arb_busy
);
    localparam int unsigned SW = DW / 8;

    typedef enum logic [1:0] {StIdle, StBusyI, StBusyD, StResp} state_e;

    state_e state;
    logic   take_d;

    // The instruction side never writes.
    logic unused_ibus;
    assign unused_ibus = ^{ibus.wdata, ibus.wstrb};

`ifdef ARB_ROUND_ROBIN_EN
    logic last_grant;  // 0 = I won last, 1 = D won last

    always_comb begin
        take_d = 1'b0;
        if (dbus.valid) begin
            take_d = !ibus.valid || !last_grant;
        end
    end
`else
    always_comb begin
        take_d = dbus.valid;
    end
`endif

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state      <= StIdle;
            arb_busy   <= 1'b0;
            mbus.valid <= 1'b0;
            mbus.addr  <= {AW{1'b0}};
            mbus.wdata <= {DW{1'b0}};
            mbus.wstrb <= {SW{1'b0}};
            ibus.ready <= 1'b0;
            ibus.rdata <= {DW{1'b0}};
            dbus.ready <= 1'b0;
            dbus.rdata <= {DW{1'b0}};
`ifdef ARB_ROUND_ROBIN_EN
            last_grant <= 1'b0;
`endif
        end else begin
            unique case (state)
                StIdle: begin
                    if (take_d) begin
                        state      <= StBusyD;
                        arb_busy   <= 1'b1;
                        mbus.valid <= 1'b1;
                        mbus.addr  <= dbus.addr;
                        mbus.wdata <= dbus.wdata;
                        mbus.wstrb <= dbus.wstrb;
`ifdef ARB_ROUND_ROBIN_EN
                        last_grant <= 1'b1;
`endif
                    end else if (ibus.valid) begin
                        state      <= StBusyI;
                        arb_busy   <= 1'b1;
                        mbus.valid <= 1'b1;
                        mbus.addr  <= ibus.addr;
                        mbus.wdata <= {DW{1'b0}};
                        mbus.wstrb <= {SW{1'b0}};
`ifdef ARB_ROUND_ROBIN_EN
                        last_grant <= 1'b0;
`endif
                    end
                end
                StBusyI: begin
                    if (mbus.ready) begin
                        state      <= StResp;
                        mbus.valid <= 1'b0;
                        ibus.rdata <= mbus.rdata;
                        ibus.ready <= 1'b1;
                    end
                end
                StBusyD: begin
                    if (mbus.ready) begin
                        state      <= StResp;
                        mbus.valid <= 1'b0;
                        dbus.rdata <= mbus.rdata;
                        dbus.ready <= 1'b1;
                    end
                end
                StResp: begin
                    // Requesters update valid/addr on this edge, so nothing is sampled here.
                    state      <= StIdle;
                    arb_busy   <= 1'b0;
                    ibus.ready <= 1'b0;
                    dbus.ready <= 1'b0;
                end
                default: state <= StIdle;
            endcase
        end
    end
endmodule

// File: tb/tb_vigna_bus_arbiter.sv
// Scoreboard bench for vigna_bus_arbiter: requester tasks, a stalling memory slave and a response monitor.
module tb_vigna_bus_arbiter;
    logic clk = 1'b0;
    logic resetn = 1'b0;
    logic arb_busy;

    always #5 clk = ~clk;

    vigna_bus_arbiter_if #(.AW(32), .DW(32)) ibus_if ();
    vigna_bus_arbiter_if #(.AW(32), .DW(32)) dbus_if ();
    vigna_bus_arbiter_if #(.AW(32), .DW(32)) mbus_if ();

    vigna_bus_arbiter #(.AW(32), .DW(32)) dut (
        .clk      (clk),
        .resetn   (resetn),
        .ibus     (ibus_if),
        .dbus     (dbus_if),
        .mbus     (mbus_if),
        .arb_busy (arb_busy)
    );

    typedef struct {
        bit          is_d;
        bit          is_wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [31:0] rdata;
    } txn_t;

    txn_t        exp_m[$];
    txn_t        exp_r[$];
    logic [31:0] mem     [64];
    logic [31:0] exp_mem [64];
    int          n_checks = 0;
    int          n_errors = 0;
    int          stall = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] strb);
        logic [31:0] r = old;
        for (int b = 0; b < 4; b++) if (strb[b]) r[b*8 +: 8] = nw[b*8 +: 8];
        return r;
    endfunction

    task automatic push_exp(input bit is_d, input logic [31:0] a, input logic [31:0] wd,
                            input logic [3:0] ws);
        txn_t t;
        t.is_d  = is_d;
        t.is_wr = (ws != 4'h0);
        t.addr  = a;
        t.wdata = is_d ? wd : 32'h0;
        t.wstrb = is_d ? ws : 4'h0;
        t.rdata = exp_mem[a[7:2]];
        if (t.is_wr) exp_mem[a[7:2]] = merge(exp_mem[a[7:2]], wd, ws);
        exp_m.push_back(t);
    endtask

    // Called at a negedge; holds valid until the ready pulse is seen.
    task automatic i_req(input logic [31:0] a);
        bit got = 0;
        ibus_if.valid = 1'b1;
        ibus_if.addr  = a;
        for (int c = 0; c < 200 && !got; c++) begin
            @(negedge clk);
            got = ibus_if.ready;
        end
        if (!got) check("i_timeout", 32'd0, 32'd1);
        ibus_if.valid = 1'b0;
    endtask

    task automatic d_req(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws);
        bit got = 0;
        dbus_if.valid = 1'b1;
        dbus_if.addr  = a;
        dbus_if.wdata = wd;
        dbus_if.wstrb = ws;
        for (int c = 0; c < 200 && !got; c++) begin
            @(negedge clk);
            got = dbus_if.ready;
        end
        if (!got) check("d_timeout", 32'd0, 32'd1);
        dbus_if.valid = 1'b0;
    endtask

    task automatic do_fetch(input logic [31:0] a);
        push_exp(1'b0, a, 32'h0, 4'h0);
        i_req(a);
    endtask

    task automatic do_data(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws);
        push_exp(1'b1, a, wd, ws);
        d_req(a, wd, ws);
    endtask

    // Memory slave: asserts ready for one cycle after `stall` extra cycles of m_valid.
    initial begin
        bit          seen = 0;
        int          cnt = 0;
        logic [31:0] s_addr = '0, s_wdata = '0;
        logic [3:0]  s_wstrb = '0;
        txn_t        t;
        mbus_if.ready = 1'b0;
        mbus_if.rdata = '0;
        forever begin
            @(negedge clk);
            if (mbus_if.ready) begin
                mbus_if.ready = 1'b0;
            end else if (!resetn || !mbus_if.valid) begin
                seen = 0;
            end else begin
                if (!seen) begin
                    seen = 1;
                    cnt = 0;
                    s_addr = mbus_if.addr;
                    s_wdata = mbus_if.wdata;
                    s_wstrb = mbus_if.wstrb;
                end else begin
                    cnt++;
                    check("m_addr_stable", mbus_if.addr, s_addr);
                    check("m_wdata_stable", mbus_if.wdata, s_wdata);
                    check("m_wstrb_stable", {28'h0, mbus_if.wstrb}, {28'h0, s_wstrb});
                end
                if (cnt >= stall) begin
                    seen = 0;
                    if (exp_m.size() == 0) begin
                        check("m_unexpected", 32'd1, 32'd0);
                    end else begin
                        t = exp_m.pop_front();
                        check("m_addr", mbus_if.addr, t.addr);
                        check("m_wdata", mbus_if.wdata, t.wdata);
                        check("m_wstrb", {28'h0, mbus_if.wstrb}, {28'h0, t.wstrb});
                        exp_r.push_back(t);
                    end
                    mbus_if.rdata = mem[mbus_if.addr[7:2]];
                    if (mbus_if.wstrb != 4'h0)
                        mem[mbus_if.addr[7:2]] = merge(mem[mbus_if.addr[7:2]], mbus_if.wdata,
                                                       mbus_if.wstrb);
                    mbus_if.ready = 1'b1;
                end
            end
        end
    end

    // Response monitor: port ownership, read data, pulse width and m_valid gap.
    initial begin
        logic prev_i = 0, prev_d = 0, prev_v = 0, had_txn = 0;
        int   gap = 0;
        txn_t t;
        forever begin
            @(negedge clk);
            if (resetn) begin
                if (ibus_if.ready || dbus_if.ready) begin
                    check("ready_onehot", {31'h0, ibus_if.ready & dbus_if.ready}, 32'd0);
                    if (ibus_if.ready) check("i_ready_width", {31'h0, prev_i}, 32'd0);
                    if (dbus_if.ready) check("d_ready_width", {31'h0, prev_d}, 32'd0);
                    if (exp_r.size() == 0) begin
                        check("resp_unexpected", 32'd1, 32'd0);
                    end else begin
                        t = exp_r.pop_front();
                        check("resp_port", {31'h0, dbus_if.ready}, {31'h0, t.is_d});
                        if (!t.is_wr)
                            check("resp_rdata", t.is_d ? dbus_if.rdata : ibus_if.rdata,
                                  t.rdata);
                    end
                end
                if (mbus_if.valid && !prev_v && had_txn)
                    check("m_gap_ge2", {31'h0, gap >= 2}, 32'd1);
                if (mbus_if.valid) begin
                    gap = 0;
                    had_txn = 1;
                end else begin
                    gap++;
                end
            end else begin
                had_txn = 0;
                gap = 0;
            end
            prev_i = ibus_if.ready;
            prev_d = dbus_if.ready;
            prev_v = mbus_if.valid;
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_m_valid"}, {31'h0, mbus_if.valid}, 32'd0);
        check({tag, "_m_addr"}, mbus_if.addr, 32'd0);
        check({tag, "_m_wstrb"}, {28'h0, mbus_if.wstrb}, 32'd0);
        check({tag, "_i_ready"}, {31'h0, ibus_if.ready}, 32'd0);
        check({tag, "_d_ready"}, {31'h0, dbus_if.ready}, 32'd0);
        check({tag, "_i_rdata"}, ibus_if.rdata, 32'd0);
        check({tag, "_d_rdata"}, dbus_if.rdata, 32'd0);
        check({tag, "_busy"}, {31'h0, arb_busy}, 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) begin
            mem[i]     = 32'hC0DE_0000 | i;
            exp_mem[i] = 32'hC0DE_0000 | i;
        end
        mem[1]     = 32'h0000_0013;
        exp_mem[1] = 32'h0000_0013;
        ibus_if.valid = 0; ibus_if.addr = 0; ibus_if.wdata = 0; ibus_if.wstrb = 0;
        dbus_if.valid = 0; dbus_if.addr = 0; dbus_if.wdata = 0; dbus_if.wstrb = 0;

        repeat (3) @(negedge clk);
        check_all_zero("reset");
        resetn = 1'b1;
        @(negedge clk);

        // Fetch only, then a data write and its read-back.
        stall = 0;
        do_fetch(32'h0000_0004);
        do_data(32'h0000_0010, 32'h3F80_0000, 4'hF);
        check("mem_word4", mem[4], 32'h3F80_0000);
        do_data(32'h0000_0010, 32'h0, 4'h0);

        // Simultaneous requests: data is served first.
        push_exp(1'b1, 32'h20, 32'h0, 4'h0);
        push_exp(1'b0, 32'h08, 32'h0, 4'h0);
        fork
            i_req(32'h08);
            d_req(32'h20, 32'h0, 4'h0);
        join

        // Slave stall with a partial write.
        stall = 5;
        do_data(32'h24, 32'hA5A5_5A5A, 4'h3);
        do_data(32'h24, 32'h0, 4'h0);
        do_fetch(32'h0C);

        // Reset while the shared port waits on a stalled data read.
        stall = 50;
        dbus_if.valid = 1'b1; dbus_if.addr = 32'h30; dbus_if.wdata = 0; dbus_if.wstrb = 0;
        push_exp(1'b1, 32'h30, 32'h0, 4'h0);
        repeat (3) @(negedge clk);
        check("pre_reset_busy", {31'h0, arb_busy}, 32'd1);
        resetn = 1'b0;
        dbus_if.valid = 1'b0;
        @(negedge clk);
        check_all_zero("midreset");
        exp_m.delete();
        exp_r.delete();
        resetn = 1'b1;
        @(negedge clk);
        stall = 1;
        do_fetch(32'h0000_0004);

        // Mixed random traffic.
        for (int n = 0; n < 20; n++) begin
            logic [31:0] a = {24'h0, 2'($urandom_range(0, 3)), 4'($urandom), 2'b00};
            stall = $urandom_range(0, 3);
            case ($urandom_range(0, 2))
                0: do_fetch(a);
                1: do_data(a, $urandom, 4'($urandom_range(1, 15)));
                default: do_data(a, 32'h0, 4'h0);
            endcase
        end

        repeat (4) @(negedge clk);
        check("exp_m_empty", exp_m.size(), 32'd0);
        check("exp_r_empty", exp_r.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule
